// File: rtl/noise_pkg.sv
// Shared definitions for the programmable noise channel.
// NF encodings, period constants, tap presets and the FB bit index.
`timescale 1ns/1ps
package noise_pkg;

  typedef enum logic [1:0] {
    NF_32    = 2'b00,
    NF_64    = 2'b01,
    NF_128   = 2'b10,
    NF_TONE3 = 2'b11
  } nf_e;

  localparam int PERIOD_32  = 32;
  localparam int PERIOD_64  = 64;
  localparam int PERIOD_128 = 128;

  // Tap presets and their matching lengths.
  localparam logic [15:0] TAPS_BBC   = 16'h0003;
  localparam logic [15:0] TAPS_SMS   = 16'h0009;
  localparam logic [15:0] TAPS_TANDY = 16'h0011;
  localparam int LEN_BBC   = 15;
  localparam int LEN_SMS   = 16;
  localparam int LEN_TANDY = 15;

  // ctrl = {FB, NF1, NF0}
  localparam int FB_BIT = 2;

  // Internal period in clk_en ticks; 0 for the external source.
  function automatic int unsigned nf_period(nf_e nf);
    unique case (nf)
      NF_32:   return PERIOD_32;
      NF_64:   return PERIOD_64;
      NF_128:  return PERIOD_128;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/noise_lfsr_gen_period_counter.sv
// Period counter: raises shift_tick on each LFSR shift condition.
// In: clk, reset, clk_en, nf, tone3_edge. Out: shift_tick.
`timescale 1ns/1ps
module noise_period_counter
  import noise_pkg::*;
#(
  parameter int COUNTER_BITS = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  nf_e  nf,
  input  logic tone3_edge,
  output logic shift_tick
);

  logic [COUNTER_BITS-1:0] cnt_q;
  logic [COUNTER_BITS-1:0] cnt_d;

  // A new period is only loaded when the running count hits
  // zero, so an NF change lets the count in flight finish.
  always_comb begin
    cnt_d      = cnt_q;
    shift_tick = 1'b0;
    if (nf == NF_TONE3) begin
      cnt_d      = '0;
      shift_tick = tone3_edge;
    end else if (clk_en) begin
      if (cnt_q == '0) begin
        cnt_d      = COUNTER_BITS'(nf_period(nf) - 1);
        shift_tick = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/noise_lfsr_gen.sv
// Programmable-length/tap noise LFSR with control latch and guard.
// In: clk, reset, clk_en, tone3_edge, ctrl_we/data, cfg_len/taps.
// Out: out (lfsr[0]), shift_strobe (shift this cycle).
`timescale 1ns/1ps
module noise_lfsr_gen
  import noise_pkg::*;
#(
  parameter int LFSR_BITS    = 16,
  parameter int COUNTER_BITS = 7,
  parameter int DEFAULT_LEN  = 15,
  parameter logic [LFSR_BITS-1:0] DEFAULT_TAPS = 16'h0003
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 tone3_edge,
  input  logic                 ctrl_we,
  input  logic [2:0]           ctrl_data,
  input  logic [4:0]           cfg_len,
  input  logic [LFSR_BITS-1:0] cfg_taps,
  output logic                 out,
  output logic                 shift_strobe
);

  function automatic logic [4:0] clamp_len(logic [4:0] l);
    if (l < 5'd2 || int'(l) > LFSR_BITS)
      return 5'(LFSR_BITS);
    return l;
  endfunction

  function automatic logic [LFSR_BITS-1:0] seed_of(
    logic [4:0] l
  );
    logic [LFSR_BITS-1:0] one;
    one = {{(LFSR_BITS-1){1'b0}}, 1'b1};
    return one << (l - 5'd1);
  endfunction

  logic [2:0]           ctrl_q, ctrl_d;
  logic [4:0]           len_q, len_d;
  logic [LFSR_BITS-1:0] taps_q, taps_d;
  logic [LFSR_BITS-1:0] lfsr_q, lfsr_d;
  logic [LFSR_BITS-1:0] shifted;
  logic [LFSR_BITS-1:0] nxt;
  logic                 fb;
  logic                 shift_tick;
  logic                 step;
  nf_e                  nf;

  assign nf = nf_e'(ctrl_q[1:0]);

  noise_period_counter #(
    .COUNTER_BITS(COUNTER_BITS)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .nf        (nf),
    .tone3_edge(tone3_edge),
    .shift_tick(shift_tick)
  );

  always_comb begin
    fb = ctrl_q[FB_BIT] ? ^(lfsr_q & taps_q)
                        : lfsr_q[0];
    shifted = lfsr_q >> 1;
    nxt     = '0;
    for (int i = 0; i < LFSR_BITS; i++) begin
      if (i < int'(len_q) - 1)
        nxt[i] = shifted[i];
      else if (i == int'(len_q) - 1)
        nxt[i] = fb;
    end
  end

  // A control write wins over a shift in the same cycle.
  assign step = shift_tick && !ctrl_we;

  always_comb begin
    ctrl_d = ctrl_q;
    len_d  = len_q;
    taps_d = taps_q;
    lfsr_d = lfsr_q;
    if (ctrl_we) begin
      ctrl_d = ctrl_data;
      len_d  = clamp_len(cfg_len);
      taps_d = cfg_taps;
      lfsr_d = seed_of(clamp_len(cfg_len));
    end else if (step) begin
      // Never let the register fall into the dead all-zero state.
      lfsr_d = (nxt == '0) ? seed_of(len_q) : nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= 3'b000;
      len_q  <= 5'(DEFAULT_LEN);
      taps_q <= DEFAULT_TAPS;
      lfsr_q <= seed_of(5'(DEFAULT_LEN));
    end else begin
      ctrl_q <= ctrl_d;
      len_q  <= len_d;
      taps_q <= taps_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign out          = lfsr_q[0];
  assign shift_strobe = step && !reset;

endmodule

// File: tb/tb_noise_lfsr_gen.sv
// Directed testbench for noise_lfsr_gen.
// Hand-computed expectations checked with immediate assertions.
`timescale 1ns/1ps
module tb_noise_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        tone3_edge;
  logic        ctrl_we;
  logic [2:0]  ctrl_data;
  logic [4:0]  cfg_len;
  logic [15:0] cfg_taps;
  logic        out_w;
  logic        strobe_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noise_lfsr_gen dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .tone3_edge  (tone3_edge),
    .ctrl_we     (ctrl_we),
    .ctrl_data   (ctrl_data),
    .cfg_len     (cfg_len),
    .cfg_taps    (cfg_taps),
    .out         (out_w),
    .shift_strobe(strobe_w)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  // Inputs change at posedge+1; combinational sampling at negedge.
  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    #4;
  endtask

  task automatic cfg(input logic [2:0] d,
                     input logic [4:0] l,
                     input logic [15:0] t);
    ctrl_we   = 1'b1;
    ctrl_data = d;
    cfg_len   = l;
    cfg_taps  = t;
  endtask

  int sd, cnt, early, zero;
  logic [11:0] pat;
  logic [15:0] exp5 [4];
  logic [4:0]  clen [6];
  logic [15:0] cseed [6];
  logic [4:0]  clen_q [6];
  logic        e;

  initial begin
    reset = 1'b1; clk_en = 1'b1; tone3_edge = 1'b0;
    ctrl_we = 1'b0; ctrl_data = '0; cfg_len = '0; cfg_taps = '0;
    adv; adv;

    // Reset state
    mid;
    chk("rst_strobe", strobe_w, 0);
    adv;
    chk("rst_lfsr", dut.lfsr_q, 32'h4000);
    chk("rst_out", out_w, 0);
    chk("rst_cnt", dut.u_cnt.cnt_q, 0);
    chk("rst_len", dut.len_q, 15);
    chk("rst_taps", dut.taps_q, 32'h0003);
    chk("rst_ctrl", dut.ctrl_q, 0);

    // Default config, clk_en always on: strobe every 32,
    // out rises after the 14th shift of the periodic ring.
    reset = 1'b0;
    for (int idx = 0; idx < 488; idx++) begin
      mid;
      sd = (idx + 31) / 32;
      chk("t1_strobe", strobe_w, (idx % 32) == 0);
      chk("t1_out", out_w, (sd % 15) == 14);
      adv;
    end

    // Periodic SMS, clk_en every 4th cycle
    reset = 1'b1; adv; reset = 1'b0;
    clk_en = 1'b0;
    cfg(3'b001, 5'd16, 16'h0009);
    mid;
    chk("t2_we_strobe", strobe_w, 0);
    adv;
    ctrl_we = 1'b0;
    chk("t2_seed", dut.lfsr_q, 32'h8000);
    for (int j = 0; j < 17 * 256; j++) begin
      clk_en = (j % 4) == 0;
      mid;
      sd = (j + 255) / 256;
      chk("t2_strobe", strobe_w, (j % 256) == 0);
      chk("t2_out", out_w, (sd % 16) == 15);
      adv;
    end

    // White BBC, full sequence clocked from tone3 each cycle
    clk_en = 1'b0;
    cfg(3'b111, 5'd15, 16'h0003);
    mid; adv;
    ctrl_we = 1'b0;
    chk("t3_seed", dut.lfsr_q, 32'h4000);
    early = 0; zero = 0; cnt = 0;
    for (int m = 1; m <= 32767; m++) begin
      tone3_edge = 1'b1;
      mid;
      if (strobe_w) cnt++;
      adv;
      if (dut.lfsr_q == 16'h0) zero++;
      if (m < 32767 && dut.lfsr_q == 16'h4000) early++;
    end
    tone3_edge = 1'b0;
    chk("t3_final", dut.lfsr_q, 32'h4000);
    chk("t3_early", early, 0);
    chk("t3_zero", zero, 0);
    chk("t3_strobes", cnt, 32767);

    // External clock, clk_en ignored
    cfg(3'b011, 5'd15, 16'h0003);
    mid; adv;
    ctrl_we = 1'b0;
    pat = 12'b0100_1001_1010;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tone3_edge = pat[c];
      clk_en = (c % 2) == 1;
      mid;
      chk("t4_strobe", strobe_w, pat[c]);
      if (strobe_w) cnt++;
      adv;
    end
    tone3_edge = 1'b0;
    chk("t4_count", cnt, 5);
    chk("t4_lfsr", dut.lfsr_q, 32'h0200);
    cfg(3'b011, 5'd8, 16'h0003);
    tone3_edge = 1'b1;
    mid;
    chk("t4_coinc_strobe", strobe_w, 0);
    adv;
    ctrl_we = 1'b0; tone3_edge = 1'b0;
    chk("t4_coinc_seed", dut.lfsr_q, 32'h0080);

    // Lock-up guard: taps 0, len 4, white, NF=00
    reset = 1'b1; adv; reset = 1'b0;
    clk_en = 1'b0;
    cfg(3'b100, 5'd4, 16'h0000);
    mid; adv;
    ctrl_we = 1'b0;
    chk("t5_seed", dut.lfsr_q, 32'h8);
    clk_en = 1'b1;
    exp5[0] = 16'h4; exp5[1] = 16'h2;
    exp5[2] = 16'h1; exp5[3] = 16'h8;
    for (int j = 0; j < 128; j++) begin
      mid;
      chk("t5_strobe", strobe_w, (j % 32) == 0);
      adv;
      if (j % 32 == 0) chk("t5_lfsr", dut.lfsr_q, exp5[j / 32]);
    end

    // Mid-period writes: reseed only, phase kept; NF change
    // lets the running count finish before the new period.
    reset = 1'b1; adv; reset = 1'b0;
    clk_en = 1'b1;
    for (int j = 0; j < 140; j++) begin
      if (j == 10) cfg(3'b000, 5'd15, 16'h0003);
      else if (j == 40) cfg(3'b001, 5'd15, 16'h0003);
      else ctrl_we = 1'b0;
      mid;
      e = (j == 0) || (j == 32) || (j == 64) || (j == 128);
      chk("t6_strobe", strobe_w, e);
      adv;
      if (j == 10) chk("t6_reseed", dut.lfsr_q, 32'h4000);
    end
    ctrl_we = 1'b0;

    // Length clamping
    clen[0] = 5'd0;  cseed[0] = 16'h8000; clen_q[0] = 5'd16;
    clen[1] = 5'd1;  cseed[1] = 16'h8000; clen_q[1] = 5'd16;
    clen[2] = 5'd2;  cseed[2] = 16'h0002; clen_q[2] = 5'd2;
    clen[3] = 5'd16; cseed[3] = 16'h8000; clen_q[3] = 5'd16;
    clen[4] = 5'd17; cseed[4] = 16'h8000; clen_q[4] = 5'd16;
    clen[5] = 5'd31; cseed[5] = 16'h8000; clen_q[5] = 5'd16;
    for (int k = 0; k < 6; k++) begin
      cfg(3'b011, clen[k], 16'h0003);
      mid; adv;
      chk("clamp_seed", dut.lfsr_q, cseed[k]);
      chk("clamp_len", dut.len_q, clen_q[k]);
    end
    ctrl_we = 1'b0;

    // Reset mid-run
    cfg(3'b110, 5'd9, 16'h0011);
    mid; adv;
    ctrl_we = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tone3_edge = j[0];
      mid; adv;
    end
    reset = 1'b1;
    tone3_edge = 1'b1;
    mid;
    chk("t7_rst_strobe", strobe_w, 0);
    adv;
    reset = 1'b0;
    tone3_edge = 1'b0;
    chk("t7_lfsr", dut.lfsr_q, 32'h4000);
    chk("t7_out", out_w, 0);
    chk("t7_cnt", dut.u_cnt.cnt_q, 0);
    chk("t7_len", dut.len_q, 15);
    chk("t7_taps", dut.taps_q, 32'h0003);
    chk("t7_ctrl", dut.ctrl_q, 0);
    mid;
    chk("t7_first_strobe", strobe_w, 1);
    adv;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/noise_lfsr_gen.md
Name: noise_lfsr_gen

Overview:
- Second-generation noise channel for the PSG. Replaces the fixed-tap noise block.
- Features:
  - runtime-programmable LFSR length and tap mask, covering SN76489/BBC, SMS/Genesis, Tandy and custom variants;
  - integrated NF period selection;
  - external clocking from tone channel 3;
  - clock-enable prescaling;
  - write-triggered LFSR reseed;
  - lock-up guard.
- Sits between the register file (noise control write) and the channel attenuator/mixer.

Parameters:
- LFSR_BITS, 16, physical LFSR width; the maximum programmable length.
- COUNTER_BITS, 7, period counter width; must hold 127.
- DEFAULT_LEN, 15, LFSR length after reset.
- DEFAULT_TAPS, 16'h0003, tap mask after reset (BBC/SG-1000).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  prescaler tick; the period counter advances only on cycles with clk_en=1
- tone3_edge  in  1  single-cycle pulse on each tone channel 3 output transition
- ctrl_we  in  1  noise control register write strobe
- ctrl_data  in  3  {FB, NF1, NF0}, latched on ctrl_we
- cfg_len  in  5  LFSR length, 2..LFSR_BITS, latched on ctrl_we
- cfg_taps  in  LFSR_BITS  white-noise tap mask, latched on ctrl_we
- out  out  1  noise output, equal to lfsr[0]
- shift_strobe  out  1  high for the one cycle in which the LFSR shifts

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - ctrl = 3'b000, len = DEFAULT_LEN, taps = DEFAULT_TAPS, counter = 0;
  - lfsr = seed = 1 << (len-1);
  - out = 0, shift_strobe = 0.
- Priority per cycle: reset > ctrl_we > shift.
- ctrl_we (any cycle, including mid-period):
  - latch ctrl_data, cfg_len and cfg_taps;
  - reload lfsr with the seed for the new length;
  - no shift occurs in that cycle, even if a shift condition is present;
  - the counter keeps running and is not reset.
- Length clamping: cfg_len < 2 or > LFSR_BITS is clamped to LFSR_BITS at latch time.
- Period source by NF = ctrl[1:0]:
  - 00 → 32 clk_en ticks; 01 → 64; 10 → 128;
  - 11 → external: the shift condition is tone3_edge=1; clk_en is ignored; the counter holds at 0.
- Internal modes (NF ≠ 11), on a clk_en=1 cycle:
  - if counter == 0: counter ← period-1 and a shift occurs;
  - else: counter ← counter-1.
  - Cycles with clk_en=0 hold the counter.
  - The first shift after reset or an NF change occurs on the first clk_en tick on which counter == 0.
- Switching NF while the counter is non-zero: the count in flight completes, then the new period loads.
- Shift, with L = len:
  - next[i] = lfsr[i+1] for i < L-1;
  - next[L-1] = fb;
  - next[i] = 0 for i ≥ L.
- Feedback:
  - FB=1 (white): fb = XOR-reduce(lfsr & taps).
  - FB=0 (periodic): fb = lfsr[0].
- Lock-up guard: if next[L-1:0] would be all zero (e.g. taps = 0 in white mode), the seed is loaded instead.
- Latency and strobe:
  - shift_strobe is asserted in the same cycle the shift condition is evaluated;
  - the new lfsr value, and therefore out, is visible the following cycle.
- The out register is lfsr[0] directly, with no extra pipeline stage.
- Widths: all counter arithmetic is modulo 2^COUNTER_BITS; the taps mask is applied only over the full LFSR_BITS.
  - Bits at or above L are always 0 and hold 0 in the lfsr, so they never contribute.

Decomposition:
- Package noise_pkg:
  - NF encodings (NF_32, NF_64, NF_128, NF_TONE3);
  - period constants 32/64/128;
  - tap presets: TAPS_BBC = 16'h0003 (len 15), TAPS_SMS = 16'h0009 (len 16), TAPS_TANDY = 16'h0011 (len 15);
  - FB bit index.
- One sub-module, noise_period_counter:
  - inputs: clk, reset, clk_en, nf, tone3_edge;
  - output: shift_tick.
- The LFSR step, feedback, guard and ctrl latching stay in noise_lfsr_gen.

Test Plan:
- Reset timing: reset, clk_en=1 constant, NF=00, default config:
  - first shift_strobe on the first cycle after reset;
  - subsequent strobes exactly 32 cycles apart;
  - out=0 until the 14th shift, then out=1.
- Periodic SMS: ctrl_we with data=3'b001, len=16, taps=16'h0009, clk_en every 4th cycle:
  - strobes every 256 clk;
  - out high for exactly 1 of every 16 shifts.
- White BBC: data=3'b100, len=15, taps=16'h0003:
  - lfsr returns to 0x4000 after exactly 32767 shifts and not before;
  - the all-zero state is never reached.
- External clock: NF=11, clk_en=0:
  - 5 tone3_edge pulses → exactly 5 shift_strobes;
  - a ctrl_we coincident with a tone3_edge → seed loaded, no shift, no strobe.
- Lock-up guard: data=3'b100, taps=0, len=4:
  - sequence 0x8 → 0x4 → 0x2 → 0x1 → 0x8 (seed reload, not zero).
- Mid-operation events:
  - ctrl_we mid-period → lfsr reseeds; counter phase unchanged (next strobe at the original time);
  - reset asserted mid-run → all state matches the reset values the next cycle.
